poly_song_reader: RTL

Parametrised successor to the three-voice song reader. Walks one song's entries in an external synchronous song ROM and dispatches note entries to any of NUM_VOICES note players, using lowest-free-voice allocation. Rest (time-advance) entries stall the walk for a beat-counted duration. Sits between the song ROM and the array of note_player instances, under control of the top-level play/song selection.

---
 rtl/poly_song_reader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/poly_song_reader.sv
// poly_song_reader: walks one song in an external synchronous song ROM and
// dispatches note entries to NUM_VOICES note players, lowest free voice
// first. Rest entries stall the walk for a beat-counted duration.
module poly_song_reader #(
  parameter int unsigned NUM_VOICES     = 3,
  parameter int unsigned NOTE_WIDTH     = 6,
  parameter int unsigned DURATION_WIDTH = 6,
  parameter int unsigned SONG_SEL_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned META_WIDTH     = 3
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             play,
  input  logic [SONG_SEL_WIDTH-1:0]                        song,
  input  logic                                             beat,
  input  logic [NUM_VOICES-1:0]                            note_done,
  output logic [SONG_SEL_WIDTH+ADDR_WIDTH-1:0]             rom_addr,
  input  logic [1+NOTE_WIDTH+DURATION_WIDTH+META_WIDTH-1:0] rom_data,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0]                 note_out,
  output logic [NUM_VOICES*DURATION_WIDTH-1:0]             dur_out,
  output logic [NUM_VOICES-1:0]                            new_note,
  output logic [NUM_VOICES-1:0]                            voice_busy,
  output logic                                             song_done
);

  localparam int unsigned ENTRY_W = 1 + NOTE_WIDTH + DURATION_WIDTH + META_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DECODE,
    S_STALL,
    S_ADVANCE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                              r_state;
  state_t                              w_next_state;

  logic [ADDR_WIDTH-1:0]               r_index;
  logic [SONG_SEL_WIDTH-1:0]           r_song_lat;
  logic [DURATION_WIDTH-1:0]           r_cnt;
  logic [NOTE_WIDTH-1:0]               r_entry_note;
  logic [DURATION_WIDTH-1:0]           r_entry_dur;
  logic [NUM_VOICES*NOTE_WIDTH-1:0]    r_note_out;
  logic [NUM_VOICES*DURATION_WIDTH-1:0] r_dur_out;
  logic [NUM_VOICES-1:0]               r_new_note;
  logic [NUM_VOICES-1:0]               r_busy;
  logic                                r_song_done;

  // Entry fields straight off the ROM bus
  logic                                w_rom_type;
  logic [NOTE_WIDTH-1:0]               w_rom_note;
  logic [DURATION_WIDTH-1:0]           w_rom_dur;
  logic                                w_unused_meta;

  // Voice allocation
  logic [NUM_VOICES-1:0]               w_free_oh;
  logic                                w_any_free;
  logic [NOTE_WIDTH-1:0]               w_disp_note;
  logic [DURATION_WIDTH-1:0]           w_disp_dur;

  // FSM control strobes
  logic                                w_latch_song;
  logic                                w_capture;
  logic                                w_dispatch;
  logic                                w_from_rom;
  logic                                w_load_cnt;
  logic                                w_dec_cnt;
  logic                                w_idx_inc;
  logic                                w_idx_wrap;
  logic                                w_set_done;

  assign w_rom_type    = rom_data[ENTRY_W-1];
  assign w_rom_note    = rom_data[ENTRY_W-2 -: NOTE_WIDTH];
  assign w_rom_dur     = rom_data[META_WIDTH +: DURATION_WIDTH];
  assign w_unused_meta = ^rom_data[META_WIDTH-1:0];

  // Lowest clear bit of the registered busy vector. A note_done arriving this
  // cycle only frees its voice from the next cycle on.
  assign w_free_oh  = ~r_busy & (r_busy + NUM_VOICES'(1));
  assign w_any_free = |w_free_oh;

  assign w_disp_note = w_from_rom ? w_rom_note : r_entry_note;
  assign w_disp_dur  = w_from_rom ? w_rom_dur  : r_entry_dur;

  assign rom_addr   = {r_song_lat, r_index};
  assign note_out   = r_note_out;
  assign dur_out    = r_dur_out;
  assign new_note   = r_new_note;
  assign voice_busy = r_busy;
  assign song_done  = r_song_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control strobes; play = 0 freezes every walking state
  always_comb begin
    w_next_state = r_state;
    w_latch_song = 1'b0;
    w_capture    = 1'b0;
    w_dispatch   = 1'b0;
    w_from_rom   = 1'b0;
    w_load_cnt   = 1'b0;
    w_dec_cnt    = 1'b0;
    w_idx_inc    = 1'b0;
    w_idx_wrap   = 1'b0;
    w_set_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (play) begin
          w_latch_song = 1'b1;
          w_next_state = S_READ;
        end
      end
      S_READ: begin
        if (play) begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (play) begin
          w_capture = 1'b1;
          if (!w_rom_type) begin
            if (w_any_free) begin
              w_dispatch   = 1'b1;
              w_from_rom   = 1'b1;
              w_next_state = S_NEXT;
            end else begin
              w_next_state = S_STALL;
            end
          end else if (w_rom_dur == '0) begin
            w_next_state = S_NEXT;
          end else begin
            w_load_cnt   = 1'b1;
            w_next_state = S_ADVANCE;
          end
        end
      end
      S_STALL: begin
        if (play && w_any_free) begin
          w_dispatch   = 1'b1;
          w_next_state = S_NEXT;
        end
      end
      S_ADVANCE: begin
        if (play && beat) begin
          w_dec_cnt = 1'b1;
          if (r_cnt == DURATION_WIDTH'(1)) begin
            w_next_state = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (play) begin
          if (&r_index) begin
            w_idx_wrap   = 1'b1;
            w_set_done   = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_idx_inc    = 1'b1;
            w_next_state = S_READ;
          end
        end
      end
      S_DONE: begin
        if (!play) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Walk position, song latch, rest counter and captured entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index      <= '0;
      r_song_lat   <= '0;
      r_cnt        <= '0;
      r_entry_note <= '0;
      r_entry_dur  <= '0;
    end else begin
      if (w_latch_song) begin
        r_song_lat <= song;
      end
      if (w_capture) begin
        r_entry_note <= w_rom_note;
        r_entry_dur  <= w_rom_dur;
      end
      if (w_load_cnt) begin
        r_cnt <= w_rom_dur;
      end else if (w_dec_cnt) begin
        r_cnt <= r_cnt - DURATION_WIDTH'(1);
      end
      if (w_idx_wrap) begin
        r_index <= '0;
      end else if (w_idx_inc) begin
        r_index <= r_index + ADDR_WIDTH'(1);
      end
    end
  end

  // Per-voice note/duration registers, load pulses and busy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_note_out <= '0;
      r_dur_out  <= '0;
      r_new_note <= '0;
      r_busy     <= '0;
    end else begin
      r_new_note <= w_dispatch ? w_free_oh : '0;
      r_busy     <= (r_busy & ~note_done) | (w_dispatch ? w_free_oh : '0);
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (w_dispatch && w_free_oh[i]) begin
          r_note_out[i*NOTE_WIDTH +: NOTE_WIDTH]         <= w_disp_note;
          r_dur_out[i*DURATION_WIDTH +: DURATION_WIDTH]  <= w_disp_dur;
        end
      end
    end
  end

  // End-of-song pulse, high during the first DONE cycle only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_song_done <= 1'b0;
    end else begin
      r_song_done <= w_set_done;
    end
  end

endmodule
